// File: rtl/mem_sdp_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : mem_sdp_pipe
//  Purpose  : Simple-dual-port buffer RAM (one write port, one read port,
//             single clock) with byte-enable writes, selectable read latency
//             (1 or 2), same-cycle write-first bypass and a post-reset clear
//             sweep. Used for operand/result staging in the matrix-multiply
//             datapath.
//  Ports    : clk         - sole clock, all logic on posedge
//             rst_n       - asynchronous active-low reset
//             wr_en       - write request
//             wr_addr     - write address (AW bits)
//             wr_be       - byte enables, bit i covers wr_data[8i+7:8i]
//             wr_data     - write data (WIDTH bits)
//             rd_en       - read request
//             rd_addr     - read address (AW bits)
//             rd_data     - read data, valid while rd_valid=1, held otherwise
//             rd_valid    - one-cycle pulse RD_LAT cycles after accepted rd_en
//             init_done   - clear sweep finished, requests are accepted
//             wr_par_flip - (MEM_PARITY_EN only) invert stored parity per byte
//             parity_err  - (MEM_PARITY_EN only) pulses with rd_valid when any
//                           returned byte fails even parity
//  Config   : define MEM_PARITY_EN to add per-byte even-parity storage.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_sdp_pipe #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 512,
    parameter int RD_LAT = 1,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [WIDTH/8-1:0] wr_be,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic               rd_en,
    input  logic [AW-1:0]      rd_addr,
    output logic [WIDTH-1:0]   rd_data,
    output logic               rd_valid,
    output logic               init_done
`ifdef MEM_PARITY_EN
    ,
    input  logic [WIDTH/8-1:0] wr_par_flip,
    output logic               parity_err
`endif
);

    localparam int c_nb = WIDTH / 8;
`ifdef MEM_PARITY_EN
    localparam int c_lw = 9;    // data byte plus its parity bit
`else
    localparam int c_lw = 8;
`endif
    localparam logic [AW-1:0] c_last_addr = AW'(DEPTH - 1);

    // ------------------------------------------------------------------------
    // Clear-sweep FSM
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_cnt;
    logic            r_init_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_INIT;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (r_cnt == c_last_addr) begin
                        r_state     <= ST_READY;
                        r_init_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_READY: begin
                    // terminal until the next reset
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    assign init_done = r_init_done;

    // ------------------------------------------------------------------------
    // Address range qualification. With a power-of-two depth every address
    // is legal; otherwise the top of the address space is unmapped.
    // ------------------------------------------------------------------------
    logic w_wr_inrange;
    logic w_rd_inrange;

    if ((1 << AW) == DEPTH) begin : g_pow2
        assign w_wr_inrange = 1'b1;
        assign w_rd_inrange = 1'b1;
    end else begin : g_npow2
        assign w_wr_inrange = (wr_addr <= c_last_addr);
        assign w_rd_inrange = (rd_addr <= c_last_addr);
    end

    logic w_ready;
    logic w_wr_go;
    logic w_rd_go;
    logic w_hit;

    assign w_ready = (r_state == ST_READY);
    assign w_wr_go = w_ready & wr_en & w_wr_inrange;
    assign w_rd_go = w_ready & rd_en;
    // Same-cycle collision: the read sees this cycle's write (per byte lane).
    assign w_hit   = w_wr_go & (wr_addr == rd_addr);

    // ------------------------------------------------------------------------
    // Storage, split into one array per byte lane so each lane has its own
    // write enable. Each lane also produces its bypassed read value.
    // ------------------------------------------------------------------------
    logic [c_nb-1:0][c_lw-1:0] w_rd_lane;

    for (genvar gi = 0; gi < c_nb; gi++) begin : g_lane
        logic [c_lw-1:0] r_lane [DEPTH];
        logic [c_lw-1:0] w_lane_wr;

`ifdef MEM_PARITY_EN
        // Even parity: stored bit equals XOR of the data byte, optionally
        // inverted to inject an error.
        assign w_lane_wr = {(^wr_data[8*gi +: 8]) ^ wr_par_flip[gi], wr_data[8*gi +: 8]};
`else
        assign w_lane_wr = wr_data[8*gi +: 8];
`endif

        // The sweep owns the array in INIT; user writes only once READY.
        always_ff @(posedge clk) begin
            if (r_state == ST_INIT) begin
                r_lane[r_cnt] <= '0;
            end else if (w_wr_go && wr_be[gi]) begin
                r_lane[wr_addr] <= w_lane_wr;
            end
        end

        assign w_rd_lane[gi] = !w_rd_inrange          ? '0 :
                               (w_hit && wr_be[gi])   ? w_lane_wr :
                                                        r_lane[rd_addr];
    end

    // ------------------------------------------------------------------------
    // Lane reassembly and parity check of the captured word
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_rd_data;
`ifdef MEM_PARITY_EN
    logic             w_rd_perr;
`endif

    always_comb begin
        w_rd_data = '0;
`ifdef MEM_PARITY_EN
        w_rd_perr = 1'b0;
`endif
        for (int b = 0; b < c_nb; b++) begin
            w_rd_data[8*b +: 8] = w_rd_lane[b][7:0];
`ifdef MEM_PARITY_EN
            w_rd_perr = w_rd_perr | (^w_rd_lane[b]);
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Read stage 1: captures the array output. Data only moves on an accepted
    // read so the output holds between results.
    // ------------------------------------------------------------------------
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= w_rd_go;
            if (w_rd_go) begin
                r_s1_data <= w_rd_data;
            end
        end
    end

`ifdef MEM_PARITY_EN
    logic r_s1_perr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_perr <= 1'b0;
        end else begin
            r_s1_perr <= w_rd_go & w_rd_perr;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Optional output register stage
    // ------------------------------------------------------------------------
    if (RD_LAT == 2) begin : g_lat2
        logic             r_s2_valid;
        logic [WIDTH-1:0] r_s2_data;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s2_valid <= 1'b0;
                r_s2_data  <= '0;
            end else begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_data <= r_s1_data;
                end
            end
        end

        assign rd_valid = r_s2_valid;
        assign rd_data  = r_s2_data;

`ifdef MEM_PARITY_EN
        logic r_s2_perr;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s2_perr <= 1'b0;
            end else begin
                r_s2_perr <= r_s1_perr;
            end
        end

        assign parity_err = r_s2_perr;
`endif
    end else begin : g_lat1
        assign rd_valid = r_s1_valid;
        assign rd_data  = r_s1_data;
`ifdef MEM_PARITY_EN
        assign parity_err = r_s1_perr;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_sdp_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_sdp_pipe
//  Purpose  : Self-checking bench for mem_sdp_pipe. Two instances with
//             DEPTH=512 (RD_LAT=1 and RD_LAT=2) share one stimulus stream and
//             are compared every cycle against an array-based reference
//             model; a third DEPTH=20 instance covers non-power-of-two depth.
//  Config   : MEM_PARITY_EN adds the parity ports and a parity sequence.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_sdp_pipe;

    localparam int DEPTH   = 512;
    localparam int S_DEPTH = 20;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        wr_en, rd_en;
    logic [8:0]  wr_addr, rd_addr;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;

    logic [31:0] d1_rd_data, d2_rd_data, d3_rd_data;
    logic        d1_rd_valid, d2_rd_valid, d3_rd_valid;
    logic        d1_init_done, d2_init_done, d3_init_done;

    logic        s_wr_en, s_rd_en;
    logic [4:0]  s_wr_addr, s_rd_addr;
    logic [3:0]  s_wr_be;
    logic [31:0] s_wr_data;

`ifdef MEM_PARITY_EN
    logic [3:0]  wr_par_flip;
    logic [3:0]  s_flip;
    logic        d1_perr, d2_perr, d3_perr;
`endif

    mem_sdp_pipe #(.WIDTH(32), .DEPTH(DEPTH), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(d1_rd_data), .rd_valid(d1_rd_valid), .init_done(d1_init_done)
`ifdef MEM_PARITY_EN
        , .wr_par_flip(wr_par_flip), .parity_err(d1_perr)
`endif
    );

    mem_sdp_pipe #(.WIDTH(32), .DEPTH(DEPTH), .RD_LAT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(d2_rd_data), .rd_valid(d2_rd_valid), .init_done(d2_init_done)
`ifdef MEM_PARITY_EN
        , .wr_par_flip(wr_par_flip), .parity_err(d2_perr)
`endif
    );

    mem_sdp_pipe #(.WIDTH(32), .DEPTH(S_DEPTH), .RD_LAT(1)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_be(s_wr_be), .wr_data(s_wr_data),
        .rd_en(s_rd_en), .rd_addr(s_rd_addr),
        .rd_data(d3_rd_data), .rd_valid(d3_rd_valid), .init_done(d3_init_done)
`ifdef MEM_PARITY_EN
        , .wr_par_flip(s_flip), .parity_err(d3_perr)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: word array, cycle count since reset release, and the
    // expected visible output of each latency flavour.
    // ------------------------------------------------------------------------
    logic [31:0] m_mem [DEPTH];
    int          m_edges;
    logic        m_p_valid;
    logic [31:0] m_p_data;
    logic        e1_valid, e2_valid;
    logic [31:0] e1_data, e2_data;

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    task automatic model_reset();
        m_edges   = 0;
        m_p_valid = 1'b0;
        m_p_data  = '0;
        e1_valid  = 1'b0;
        e1_data   = '0;
        e2_valid  = 1'b0;
        e2_data   = '0;
    endtask

    task automatic model_edge();
        logic        r_v;
        logic [31:0] r_d;
        if (!rst_n) return;
        r_v = 1'b0;
        r_d = '0;
        if (m_edges >= DEPTH) begin
            if (rd_en) begin
                r_v = 1'b1;
                r_d = m_mem[rd_addr];
                if (wr_en && wr_addr == rd_addr) r_d = merge(r_d, wr_data, wr_be);
            end
            if (wr_en) m_mem[wr_addr] = merge(m_mem[wr_addr], wr_data, wr_be);
        end else begin
            m_mem[9'(m_edges)] = '0;
        end
        m_edges++;
        e2_valid = m_p_valid;
        if (m_p_valid) e2_data = m_p_data;
        m_p_valid = r_v;
        m_p_data  = r_d;
        e1_valid  = r_v;
        if (r_v) e1_data = r_d;
    endtask

    task automatic check_all();
        chk("lat1_valid", d1_rd_valid, e1_valid);
        chk("lat1_data",  d1_rd_data,  e1_data);
        chk("lat1_init",  d1_init_done, m_edges >= DEPTH);
        chk("lat2_valid", d2_rd_valid, e2_valid);
        chk("lat2_data",  d2_rd_data,  e2_data);
        chk("lat2_init",  d2_init_done, m_edges >= DEPTH);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        wr_en = 1'b0; rd_en = 1'b0; wr_addr = '0; rd_addr = '0; wr_be = '0; wr_data = '0;
        s_wr_en = 1'b0; s_rd_en = 1'b0; s_wr_addr = '0; s_rd_addr = '0; s_wr_be = '0; s_wr_data = '0;
`ifdef MEM_PARITY_EN
        wr_par_flip = '0;
        s_flip      = '0;
`endif
    endtask

    task automatic rand_req();
        wr_en   = 1'($urandom_range(0, 1));
        rd_en   = 1'($urandom_range(0, 1));
        wr_be   = 4'($urandom_range(0, 15));
        wr_data = $urandom();
        wr_addr = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 15));
        rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 9'($urandom_range(0, 15));
    endtask

    // Called just after a posedge; asserts reset asynchronously mid-cycle.
    task automatic assert_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        tick();
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------------
    // Directed vectors: one request per cycle, expected lat-1 output after it
    // ------------------------------------------------------------------------
    typedef struct {
        logic        we;
        logic [8:0]  wa;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        re;
        logic [8:0]  ra;
        logic        ev;
        logic [31:0] ed;
    } vec_t;

    vec_t vecs [12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n1, n3;
        logic [31:0] lat_vals [3];

        vecs[0]  = '{1'b0, 9'd0, 4'h0, 32'h0,        1'b1, 9'd0,   1'b1, 32'h00000000};
        vecs[1]  = '{1'b0, 9'd0, 4'h0, 32'h0,        1'b1, 9'd511, 1'b1, 32'h00000000};
        vecs[2]  = '{1'b1, 9'd5, 4'hF, 32'hDEADBEEF, 1'b0, 9'd0,   1'b0, 32'h00000000};
        vecs[3]  = '{1'b1, 9'd5, 4'h5, 32'h11223344, 1'b0, 9'd0,   1'b0, 32'h00000000};
        vecs[4]  = '{1'b0, 9'd0, 4'h0, 32'h0,        1'b1, 9'd5,   1'b1, 32'hDE22BE44};
        vecs[5]  = '{1'b1, 9'd7, 4'hF, 32'hAAAAAAAA, 1'b0, 9'd0,   1'b0, 32'hDE22BE44};
        vecs[6]  = '{1'b1, 9'd7, 4'h3, 32'h55555555, 1'b1, 9'd7,   1'b1, 32'hAAAA5555};
        vecs[7]  = '{1'b0, 9'd0, 4'h0, 32'h0,        1'b1, 9'd7,   1'b1, 32'hAAAA5555};
        vecs[8]  = '{1'b1, 9'd5, 4'h0, 32'hFFFFFFFF, 1'b1, 9'd5,   1'b1, 32'hDE22BE44};
        vecs[9]  = '{1'b0, 9'd0, 4'h0, 32'h0,        1'b0, 9'd0,   1'b0, 32'hDE22BE44};
        vecs[10] = '{1'b1, 9'd5, 4'hF, 32'hCAFEBABE, 1'b1, 9'd6,   1'b1, 32'h00000000};
        vecs[11] = '{1'b0, 9'd0, 4'h0, 32'h0,        1'b1, 9'd5,   1'b1, 32'hCAFEBABE};

        idle();
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        assert_reset();

        // First sweep, with requests that must all be ignored.
        for (int i = 0; i < DEPTH; i++) begin
            rand_req();
            tick();
        end
        idle();

        // Directed vectors.
        for (int i = 0; i < 12; i++) begin
            wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_be = vecs[i].be; wr_data = vecs[i].wd;
            rd_en = vecs[i].re; rd_addr = vecs[i].ra;
            tick();
            chk($sformatf("vec%0d_valid", i), d1_rd_valid, vecs[i].ev);
            chk($sformatf("vec%0d_data", i),  d1_rd_data,  vecs[i].ed);
        end
        idle();

        // Latency-2 back-to-back reads.
        lat_vals[0] = 32'h11111111;
        lat_vals[1] = 32'h22222222;
        lat_vals[2] = 32'h33333333;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_be = 4'hF; wr_addr = 9'(i + 1); wr_data = lat_vals[i];
            tick();
        end
        idle();
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin
                rd_en = 1'b1; rd_addr = 9'(i + 1);
            end else begin
                rd_en = 1'b0;
            end
            tick();
            chk($sformatf("lat2_seq%0d_valid", i), d2_rd_valid, (i >= 1 && i <= 3));
            if (i >= 1) chk($sformatf("lat2_seq%0d_data", i), d2_rd_data, lat_vals[(i > 3) ? 2 : i - 1]);
        end
        idle();

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            rand_req();
            tick();
        end
        idle();

        // Reset at sweep count 100, then time the restarted sweep.
        tick();
        assert_reset();
        for (int i = 0; i < 100; i++) begin
            rand_req();
            tick();
        end
        assert_reset();
        n1 = 0;
        n3 = 0;
        for (int n = 1; n <= 700 && n1 == 0; n++) begin
            rand_req();
            tick();
            if (d1_init_done && n1 == 0) n1 = n;
            if (d3_init_done && n3 == 0) n3 = n;
        end
        chk("sweep_len", n1, DEPTH);
        chk("small_sweep_len", n3, S_DEPTH);
        idle();

        // Non-power-of-two depth: out-of-range write dropped, read returns 0.
        s_wr_en = 1'b1; s_wr_be = 4'hF; s_wr_addr = 5'd19; s_wr_data = 32'hCAFEF00D;
        tick();
        s_wr_addr = 5'd25; s_wr_data = 32'h12345678;
        tick();
        s_wr_en = 1'b0; s_rd_en = 1'b1; s_rd_addr = 5'd19;
        tick();
        chk("small_r19_valid", d3_rd_valid, 1'b1);
        chk("small_r19_data", d3_rd_data, 32'hCAFEF00D);
        s_rd_addr = 5'd25;
        tick();
        chk("small_r25_valid", d3_rd_valid, 1'b1);
        chk("small_r25_data", d3_rd_data, 32'h0);
        s_rd_addr = 5'd19;
        tick();
        s_rd_addr = 5'd20;
        tick();
        chk("small_r20_data", d3_rd_data, 32'h0);
        idle();
        tick();
        chk("small_idle_valid", d3_rd_valid, 1'b0);

`ifdef MEM_PARITY_EN
        wr_en = 1'b1; wr_be = 4'hF; wr_addr = 9'd9; wr_data = 32'h01020304; wr_par_flip = 4'b0100;
        tick();
        idle();
        rd_en = 1'b1; rd_addr = 9'd9;
        tick();
        chk("par_flip_err", d1_perr, 1'b1);
        chk("par_flip_valid", d1_rd_valid, 1'b1);
        idle();
        tick();
        chk("par_err_pulse", d1_perr, 1'b0);
        wr_en = 1'b1; wr_be = 4'hF; wr_addr = 9'd9; wr_data = 32'h01020304;
        tick();
        idle();
        rd_en = 1'b1; rd_addr = 9'd9;
        tick();
        chk("par_clean_err", d1_perr, 1'b0);
        idle();
`endif

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
